// File: rtl/sram_responder.sv
// Clocked responder model of the board's 16-bit asynchronous SRAM: small register-file
// store with byte lanes, end-of-pulse write commit, programmable read latency, monitors.
module sram_responder #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [19:0]      SRAM_ADDR,
  inout  wire  [15:0]      SRAM_DQ,
  input  logic             SRAM_CE_N,
  input  logic             SRAM_OE_N,
  input  logic             SRAM_WE_N,
  input  logic             SRAM_UE_N,
  input  logic             SRAM_LE_N,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] rd_count,
  output logic             err_oob,
  output logic             busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned LAT_W = 2;
  localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic        s_ce, s_we, s_oe, s_ue, s_le;
  logic [19:0] s_addr;
  logic [15:0] s_dq;

  logic [19:0] w_addr;
  logic [15:0] w_data;
  logic        w_ue, w_le;
  logic [19:0] r_addr;
  logic [LAT_W-1:0] lat_cnt;
  logic        rd_hit_q;
  logic [15:0] mem [DEPTH];

  logic wr_latch_c, commit_c, rd_start_c, rd_end_c;
  logic elapsed_c, wr_en_c, drive_hi_c, drive_lo_c;
  logic [15:0] rd_data_c;

  function automatic logic is_oob(input logic [19:0] a);
    return (a >> ADDR_W) != 20'd0;
  endfunction

  // Pin sampling; all FSM decisions work from these registered copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ce   <= 1'b1;
      s_we   <= 1'b1;
      s_oe   <= 1'b1;
      s_ue   <= 1'b1;
      s_le   <= 1'b1;
      s_addr <= '0;
      s_dq   <= '0;
    end else begin
      s_ce   <= SRAM_CE_N;
      s_we   <= SRAM_WE_N;
      s_oe   <= SRAM_OE_N;
      s_ue   <= SRAM_UE_N;
      s_le   <= SRAM_LE_N;
      s_addr <= SRAM_ADDR;
      s_dq   <= SRAM_DQ;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  assign elapsed_c = (state_q == ST_READ) && (lat_cnt == LAT_MAX) && (s_addr == r_addr);

  always_comb begin
    state_d    = state_q;
    wr_latch_c = 1'b0;
    commit_c   = 1'b0;
    rd_start_c = 1'b0;
    rd_end_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!s_ce && !s_we) begin
          state_d    = ST_WRITE;
          wr_latch_c = 1'b1;
        end else if (!s_ce && !s_oe) begin
          state_d    = ST_READ;
          rd_start_c = 1'b1;
        end
      end
      ST_WRITE: begin
        if (s_ce || s_we) begin
          state_d  = ST_IDLE;
          commit_c = 1'b1;
        end else begin
          wr_latch_c = 1'b1;
          commit_c   = (s_addr != w_addr);
        end
      end
      ST_READ: begin
        if (s_ce) begin
          state_d  = ST_IDLE;
          rd_end_c = 1'b1;
        end else if (!s_we) begin
          state_d    = ST_WRITE;
          wr_latch_c = 1'b1;
          rd_end_c   = 1'b1;
        end else if (s_oe) begin
          state_d  = ST_IDLE;
          rd_end_c = 1'b1;
        end else if (s_addr != r_addr) begin
          rd_start_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign wr_en_c = commit_c && !is_oob(w_addr) && !(w_ue && w_le);

  // Write staging and read latency tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_addr   <= '0;
      w_data   <= '0;
      w_ue     <= 1'b1;
      w_le     <= 1'b1;
      r_addr   <= '0;
      lat_cnt  <= '0;
      rd_hit_q <= 1'b0;
    end else begin
      if (wr_latch_c) begin
        w_addr <= s_addr;
        w_data <= s_dq;
        w_ue   <= s_ue;
        w_le   <= s_le;
      end
      if (rd_start_c) begin
        r_addr  <= s_addr;
        lat_cnt <= '0;
      end else if (state_q == ST_READ && lat_cnt != LAT_MAX) begin
        lat_cnt <= lat_cnt + LAT_W'(1);
      end
      rd_hit_q <= (state_q == ST_READ && state_d == ST_READ) ? (rd_hit_q | elapsed_c) : 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (wr_en_c) begin
      if (!w_ue) mem[w_addr[ADDR_W-1:0]][15:8] <= w_data[15:8];
      if (!w_le) mem[w_addr[ADDR_W-1:0]][7:0]  <= w_data[7:0];
    end
  end

  // Monitors: counters saturate, out-of-range flag is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count <= '0;
      rd_count <= '0;
      err_oob  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      if (wr_en_c && wr_count != CNT_MAX) wr_count <= wr_count + CNT_W'(1);
      if (rd_end_c && (rd_hit_q || elapsed_c) && rd_count != CNT_MAX)
        rd_count <= rd_count + CNT_W'(1);
      if ((wr_latch_c || rd_start_c) && is_oob(s_addr)) err_oob <= 1'b1;
      busy <= (state_d != ST_IDLE);
    end
  end

  // Drive enables use raw pins so the bus is released in the same cycle it is turned.
  assign rd_data_c  = is_oob(r_addr) ? 16'h0000 : mem[r_addr[ADDR_W-1:0]];
  assign drive_hi_c = elapsed_c && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && !SRAM_UE_N;
  assign drive_lo_c = elapsed_c && !SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N && !SRAM_LE_N;

  assign SRAM_DQ[15:8] = drive_hi_c ? rd_data_c[15:8] : 8'bz;
  assign SRAM_DQ[7:0]  = drive_lo_c ? rd_data_c[7:0]  : 8'bz;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder: directed cases plus randomized transactions
// checked against a transaction-level memory model.
module tb_sram_responder;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned RD_LAT = 3;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned DEPTH  = 2 ** ADDR_W;
  localparam int          SAT    = 2 ** CNT_W - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [19:0]      addr;
  logic             ce_n, oe_n, we_n, ue_n, le_n;
  logic [15:0]      dq_drv;
  logic             dq_en;
  wire  [15:0]      dq;
  logic [CNT_W-1:0] wr_count, rd_count;
  logic             err_oob, busy;

  assign dq = dq_en ? dq_drv : 16'bz;

  // Released lanes read back as the pull-up value.
  for (genvar i = 0; i < 16; i++) begin : g_pu
    pullup (dq[i]);
  end

  sram_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .SRAM_ADDR(addr), .SRAM_DQ(dq),
    .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n),
    .SRAM_UE_N(ue_n), .SRAM_LE_N(le_n),
    .wr_count(wr_count), .rd_count(rd_count), .err_oob(err_oob), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] m_mem [DEPTH];
  int          m_wr, m_rd;
  bit          m_err;
  bit          p_valid;
  logic [19:0] p_a;
  logic [15:0] p_d;
  logic        p_ue, p_le;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_oob(input logic [19:0] a);
    return a >= 20'(DEPTH);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = 16'h0000;
    m_wr = 0; m_rd = 0; m_err = 1'b0; p_valid = 1'b0;
  endtask

  task automatic m_commit(input logic [19:0] a, input logic [15:0] d, input logic ue, input logic le);
    if (m_oob(a) || (ue && le)) return;
    if (!ue) m_mem[a[ADDR_W-1:0]][15:8] = d[15:8];
    if (!le) m_mem[a[ADDR_W-1:0]][7:0]  = d[7:0];
    if (m_wr < SAT) m_wr++;
  endtask

  function automatic logic [15:0] exp_dq(input logic [19:0] a, input logic ue, input logic le, input bit drv);
    logic [15:0] d;
    logic [15:0] r;
    d = m_oob(a) ? 16'h0000 : m_mem[a[ADDR_W-1:0]];
    r[15:8] = (drv && !ue) ? d[15:8] : 8'hFF;
    r[7:0]  = (drv && !le) ? d[7:0]  : 8'hFF;
    return r;
  endfunction

  task automatic settle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; dq_en = 1'b0;
    repeat (2) @(negedge clk);
    check("wr_count", 32'(wr_count), 32'(m_wr));
    check("rd_count", 32'(rd_count), 32'(m_rd));
    check("err_oob", 32'(err_oob), 32'(m_err));
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  // Hold one write word on the pins; a new address while CE_N stays low commits the old one.
  task automatic wr_word(input logic [19:0] a, input logic [15:0] d, input logic ue, input logic le,
                         input int hold, input logic oe);
    if (p_valid && p_a != a) m_commit(p_a, p_d, p_ue, p_le);
    p_valid = 1'b1; p_a = a; p_d = d; p_ue = ue; p_le = le;
    if (m_oob(a)) m_err = 1'b1;
    addr = a; dq_drv = d; dq_en = 1'b1; ue_n = ue; le_n = le;
    ce_n = 1'b0; we_n = 1'b0; oe_n = oe;
    for (int j = 0; j < hold; j++) begin
      @(negedge clk);
      check("wr_dq_owned", 32'(dq), 32'(d));
    end
  endtask

  task automatic wr_end(input bit keep_we);
    if (p_valid) m_commit(p_a, p_d, p_ue, p_le);
    p_valid = 1'b0;
    ce_n = 1'b1; oe_n = 1'b1; we_n = keep_we ? 1'b0 : 1'b1; dq_en = keep_we;
    @(negedge clk);
  endtask

  task automatic rd_seg(input logic [19:0] a, input logic ue, input logic le, input int len,
                        inout bit hit);
    if (m_oob(a)) m_err = 1'b1;
    addr = a; ue_n = ue; le_n = le; dq_en = 1'b0;
    ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
    for (int j = 1; j <= len; j++) begin
      @(negedge clk);
      check("rd_dq", 32'(dq), 32'(exp_dq(a, ue, le, j >= int'(RD_LAT) + 1)));
    end
    if (len >= int'(RD_LAT) + 1) hit = 1'b1;
  endtask

  task automatic rd_end(input bit hit);
    if (hit && m_rd < SAT) m_rd++;
    settle();
  endtask

  task automatic rd(input logic [19:0] a, input logic ue, input logic le, input int len);
    bit hit;
    hit = 1'b0;
    rd_seg(a, ue, le, len, hit);
    rd_end(hit);
  endtask

  function automatic logic [19:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 20'($urandom_range(16, 20'hFFFFF));
    return 20'($urandom_range(0, int'(DEPTH) - 1));
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit          hit;
    int          kind, n, len;
    logic [19:0] a;

    m_reset();
    rst_n = 1'b0; addr = '0; dq_drv = '0; dq_en = 1'b0;
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; ue_n = 1'b1; le_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_dq", 32'(dq), 32'h0000FFFF);
    check("rst_wr", 32'(wr_count), 32'd0);
    check("rst_rd", 32'(rd_count), 32'd0);
    check("rst_err", 32'(err_oob), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single lower-lane write then read with only the lower lane enabled.
    wr_word(20'd2, 16'h00A5, 1'b1, 1'b0, 2, 1'b1);
    check("t1_busy", 32'(busy), 32'd1);
    wr_end(1'b0);
    settle();
    check("t1_wr", 32'(wr_count), 32'd1);
    rd(20'd2, 1'b1, 1'b0, RD_LAT + 1);
    check("t1_rd", 32'(rd_count), 32'd1);

    // WE_N held low, CE_N pulsed per word.
    for (int i = 0; i < 4; i++) begin
      wr_word(20'(i), 16'(4 - i), 1'b0, 1'b0, 1, 1'b1);
      wr_end(1'b1);
    end
    settle();
    check("t2_wr", 32'(wr_count), 32'd5);
    for (int i = 0; i < 4; i++) rd(20'(i), 1'b0, 1'b0, RD_LAT + 2);

    // Latency restart on address change.
    hit = 1'b0;
    rd_seg(20'd1, 1'b0, 1'b0, RD_LAT + 2, hit);
    rd_seg(20'd3, 1'b0, 1'b0, RD_LAT + 2, hit);
    rd_end(hit);

    // Out-of-range write aliasing onto word 0 must not land.
    wr_word(20'h00010, 16'hBEEF, 1'b0, 1'b0, 2, 1'b1);
    wr_end(1'b0);
    settle();
    check("t4_err", 32'(err_oob), 32'd1);
    check("t4_wr", 32'(wr_count), 32'd5);
    rd(20'd0, 1'b0, 1'b0, RD_LAT + 1);
    rd(20'h00010, 1'b0, 1'b0, RD_LAT + 1);

    // OE_N and WE_N low together is a write; OE_N rising releases DQ at once.
    wr_word(20'd6, 16'h5A3C, 1'b0, 1'b0, 3, 1'b0);
    wr_end(1'b0);
    settle();
    hit = 1'b0;
    rd_seg(20'd6, 1'b0, 1'b0, RD_LAT + 1, hit);
    oe_n = 1'b1;
    #1;
    check("t5_oe_release", 32'(dq), 32'h0000FFFF);
    rd_end(hit);

    // Randomized writes, bursts and reads against the model.
    for (int t = 0; t < 120; t++) begin
      kind = $urandom_range(0, 1);
      if (kind == 0) begin
        n = $urandom_range(1, 3);
        for (int k = 0; k < n; k++)
          wr_word(rand_addr(), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  $urandom_range(1, 3), 1'b1);
        wr_end(1'b0);
        settle();
      end else begin
        hit = 1'b0;
        a = rand_addr();
        if ($urandom_range(0, 3) == 0) begin
          rd_seg(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 6), hit);
          a = a ^ 20'd1;
        end
        len = $urandom_range(1, 6);
        if (len == int'(RD_LAT)) len++;
        rd_seg(a, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), len, hit);
        rd_end(hit);
      end
    end

    // Reset in the middle of a write discards it.
    wr_word(20'd3, 16'h1234, 1'b0, 1'b0, 2, 1'b1);
    rst_n = 1'b0;
    dq_en = 1'b0;
    #1;
    check("t6_dq", 32'(dq), 32'h0000FFFF);
    check("t6_wr", 32'(wr_count), 32'd0);
    check("t6_rd", 32'(rd_count), 32'd0);
    check("t6_err", 32'(err_oob), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);
    m_reset();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(20'd3, 1'b0, 1'b0, RD_LAT + 1);

    // Read counter saturation.
    for (int i = 0; i < 300; i++) rd(20'($urandom_range(0, int'(DEPTH) - 1)), 1'b0, 1'b0, RD_LAT + 1);
    check("t6_rd_sat", 32'(rd_count), 32'(SAT));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
